sram_port_arbiter: RTL and testbench

//   Shares the single read/write port (port 0) of the 16x32 OpenRAM macro between two requesters:
//   the UART-side SRAM controller (HOST) and the DPU.
//   - Arbitrates one access per cycle and registers the winning command onto the SRAM pins.
//   - Tracks read latency and returns each read word with rvalid to the requester that issued it.
//   - Supports a bounded lock so the DPU (or HOST) can issue read-modify-write sequences without interleaving.

---
 rtl/sram_arb_pkg.sv | 31 +++
 rtl/sram_arb_rd_pipe.sv | 47 ++++
 rtl/sram_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// ----------------------------------------------------------------------------
// sram_arb_pkg
//   Shared types for the SRAM port-0 arbiter. It defines the lock-owner
//   encoding and the requester id that travels with each read down the
//   return pipe.
//   Ports: none (package).
// ----------------------------------------------------------------------------
package sram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_DPU  = 2'd2
    } owner_t;

    typedef enum logic {
        ID_HOST = 1'b0,
        ID_DPU  = 1'b1
    } req_id_t;

    localparam int MAX_READ_LAT = 3;

    function automatic req_id_t other_id(input req_id_t id);
        return (id == ID_HOST) ? ID_DPU : ID_HOST;
    endfunction

    function automatic owner_t id_to_owner(input req_id_t id);
        return (id == ID_HOST) ? OWN_HOST : OWN_DPU;
    endfunction

endpackage

// File: rtl/sram_arb_rd_pipe.sv
// ----------------------------------------------------------------------------
// sram_arb_rd_pipe
//   Read-return tracker. A {valid, id} token enters on every read grant and
//   emerges 1+READ_LAT cycles later, in the cycle the SRAM dout is valid.
//   It has no stall and no backpressure. Reset drops every in-flight token.
//   Ports:
//     clk, reset     clock / synchronous active-high reset
//     rd_push_i      a read was granted this cycle
//     rd_id_i        requester that owns that read
//     h_rvalid_o     HOST read word on rdata this cycle
//     d_rvalid_o     DPU read word on rdata this cycle
// ----------------------------------------------------------------------------
module sram_arb_rd_pipe
    import sram_arb_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    rd_push_i,
    input  req_id_t rd_id_i,
    output logic    h_rvalid_o,
    output logic    d_rvalid_o
);

    localparam int DEPTH = 1 + READ_LAT;

    logic    [DEPTH-1:0] vld_q;
    req_id_t             id_q [DEPTH];

    // Only the valid bits need clearing; ids are don't-care without valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[DEPTH-2:0], rd_push_i};
        end
        id_q[0] <= rd_id_i;
        for (int i = 1; i < DEPTH; i++) begin
            id_q[i] <= id_q[i-1];
        end
    end

    assign h_rvalid_o = vld_q[DEPTH-1] && (id_q[DEPTH-1] == ID_HOST);
    assign d_rvalid_o = vld_q[DEPTH-1] && (id_q[DEPTH-1] == ID_DPU);

endmodule

// File: rtl/sram_port_arbiter.sv
// ----------------------------------------------------------------------------
// sram_port_arbiter
//   Shares port 0 of the 16x32 OpenRAM macro between the HOST (UART SRAM
//   controller) and the DPU. It grants one access per cycle, combinationally,
//   and registers the winning command onto the SRAM pins. Read words are routed
//   back with a per-requester rvalid. A bounded lock (LOCK_MAX grants) lets one
//   requester run read-modify-write sequences without interleaving.
//   Optional feature: define SRAM_ARB_RR_EN to use round-robin instead of fixed
//   HOST priority for uncontended-owner ties.
//   Ports:
//     clk, reset                 clock / synchronous active-high reset
//     h_req/h_we/h_lock/h_addr/h_wdata, h_gnt, h_rvalid   HOST side
//     d_req/d_we/d_lock/d_addr/d_wdata, d_gnt, d_rvalid   DPU side
//     rdata                      read data (sram_dout), qualified by *_rvalid
//     sram_csb_n/sram_we_n/sram_addr/sram_din   registered SRAM command
//     sram_dout                  SRAM read data
// ----------------------------------------------------------------------------
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              h_req,
    input  logic              h_we,
    input  logic              h_lock,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              sram_csb_n,
    output logic              sram_we_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    owner_t             owner_q, owner_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic               fair_vld_q, fair_vld_d;
    req_id_t            fair_id_q, fair_id_d;
    logic               csb_n_q, csb_n_d, we_n_q, we_n_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  din_q, din_d;

    logic               tie_host, any_gnt, win_we, win_lock, owner_req;
    req_id_t            win_id;

`ifdef SRAM_ARB_RR_EN
    req_id_t            last_q, last_d;
`endif

    // Tie-break when both request and nobody owns the port. A pending
    // forced-release handover outranks the normal policy.
    always_comb begin
        tie_host = 1'b1;
        if (fair_vld_q) begin
            tie_host = (fair_id_q == ID_HOST);
        end else begin
`ifdef SRAM_ARB_RR_EN
            tie_host = (last_q == ID_DPU);
`else
            tie_host = 1'b1;
`endif
        end
    end

    always_comb begin
        h_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            case (owner_q)
                OWN_HOST: h_gnt = h_req;
                OWN_DPU:  d_gnt = d_req;
                default: begin
                    h_gnt = h_req && (!d_req || tie_host);
                    d_gnt = d_req && (!h_req || !tie_host);
                end
            endcase
        end
    end

    assign any_gnt   = h_gnt | d_gnt;
    assign win_id    = h_gnt ? ID_HOST : ID_DPU;
    assign win_we    = h_gnt ? h_we   : d_we;
    assign win_lock  = h_gnt ? h_lock : d_lock;
    assign owner_req = (owner_q == OWN_HOST) ? h_req :
                       (owner_q == OWN_DPU)  ? d_req : 1'b0;

    // Lock FSM: a locked grant claims or extends ownership. The LOCK_MAX-th
    // consecutive locked grant hands the next contention to the other side.
    always_comb begin
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        fair_vld_d = fair_vld_q;
        fair_id_d  = fair_id_q;
        if (any_gnt) begin
            fair_vld_d = 1'b0;
            if (win_lock) begin
                if (lock_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                    owner_d    = OWN_NONE;
                    lock_cnt_d = '0;
                    fair_vld_d = 1'b1;
                    fair_id_d  = other_id(win_id);
                end else begin
                    owner_d    = id_to_owner(win_id);
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end else begin
                owner_d    = OWN_NONE;
                lock_cnt_d = '0;
            end
        end else if ((owner_q != OWN_NONE) && !owner_req) begin
            owner_d    = OWN_NONE;
            lock_cnt_d = '0;
        end
    end

    // Command stage: pins go idle after a cycle with no grant; addr/din hold.
    always_comb begin
        csb_n_d = ~any_gnt;
        we_n_d  = ~(any_gnt & win_we);
        addr_d  = addr_q;
        din_d   = din_q;
        if (any_gnt) begin
            addr_d = h_gnt ? h_addr  : d_addr;
            din_d  = h_gnt ? h_wdata : d_wdata;
        end
    end

`ifdef SRAM_ARB_RR_EN
    assign last_d = any_gnt ? win_id : last_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= OWN_NONE;
            lock_cnt_q <= '0;
            fair_vld_q <= 1'b0;
            fair_id_q  <= ID_HOST;
            csb_n_q    <= 1'b1;
            we_n_q     <= 1'b1;
            addr_q     <= '0;
            din_q      <= '0;
`ifdef SRAM_ARB_RR_EN
            last_q     <= ID_DPU;
`endif
        end else begin
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            fair_vld_q <= fair_vld_d;
            fair_id_q  <= fair_id_d;
            csb_n_q    <= csb_n_d;
            we_n_q     <= we_n_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
`ifdef SRAM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign sram_csb_n = csb_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_addr  = addr_q;
    assign sram_din   = din_q;
    assign rdata      = sram_dout;

    sram_arb_rd_pipe #(
        .READ_LAT (READ_LAT)
    ) u_rd_pipe (
        .clk        (clk),
        .reset      (reset),
        .rd_push_i  (any_gnt & ~win_we),
        .rd_id_i    (win_id),
        .h_rvalid_o (h_rvalid),
        .d_rvalid_o (d_rvalid)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    localparam int RL   = 1;
    localparam int LMAX = 4;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        h_req = 0, h_we = 0, h_lock = 0, d_req = 0, d_we = 0, d_lock = 0;
    logic [3:0]  h_addr = 0, d_addr = 0;
    logic [31:0] h_wdata = 0, d_wdata = 0;
    logic        h_gnt, h_rvalid, d_gnt, d_rvalid, sram_csb_n, sram_we_n;
    logic [31:0] rdata, sram_din, sram_dout;
    logic [3:0]  sram_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(4), .DATA_W(32), .READ_LAT(RL), .LOCK_MAX(LMAX)) dut (
        .clk(clk), .reset(reset),
        .h_req(h_req), .h_we(h_we), .h_lock(h_lock), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .rdata(rdata), .sram_csb_n(sram_csb_n), .sram_we_n(sram_we_n),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // Behavioural stand-in for the OpenRAM macro: samples pins at the clock
    // edge, read data appears RL cycles after the pin cycle.
    logic [31:0] mem [16];
    logic [31:0] dline [RL];
    always @(posedge clk) begin
        if (!sram_csb_n && !sram_we_n) mem[sram_addr] <= sram_din;
        if (!sram_csb_n && sram_we_n) dline[0] <= mem[sram_addr];
        for (int i = 1; i < RL; i++) dline[i] <= dline[i-1];
    end
    assign sram_dout = dline[RL-1];

    task automatic drv(input bit hr, input bit hw, input bit hl, input logic [3:0] ha, input logic [31:0] hd,
                       input bit dr, input bit dw, input bit dl, input logic [3:0] da, input logic [31:0] dd);
        @(negedge clk);
        h_req = hr; h_we = hw; h_lock = hl; h_addr = ha; h_wdata = hd;
        d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = dd;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        h_req = 0; d_req = 0; h_lock = 0; d_lock = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; h_req = 1; d_req = 1; h_we = 0; d_we = 0;
        @(negedge clk);
        #1;
        checks++; if (sram_csb_n !== 1'b1) begin errors++; $display("FAIL rst_csb got %b want 1", sram_csb_n); end
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL rst_we got %b want 1", sram_we_n); end
        checks++; if (sram_addr !== 4'd0) begin errors++; $display("FAIL rst_addr got %h want 0", sram_addr); end
        checks++; if (sram_din !== 32'd0) begin errors++; $display("FAIL rst_din got %h want 0", sram_din); end
        checks++; if (h_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got %b%b want 00", h_gnt, d_gnt); end
        checks++; if (h_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b%b want 00", h_rvalid, d_rvalid); end
        @(negedge clk);
        reset = 1'b0; h_req = 0; d_req = 0;
    endtask

    task automatic test_write_read();
        do_reset();
        drv(1, 1, 0, 4'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        checks++; if (h_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt got %b%b want 10", h_gnt, d_gnt); end
        drv(1, 0, 0, 4'd3, 32'h0, 0, 0, 0, 0, 0);
        checks++; if (h_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt got %b want 1", h_gnt); end
        checks++; if ({sram_csb_n, sram_we_n} !== 2'b00 || sram_addr !== 4'd3 || sram_din !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_pins got csb%b we%b a%h d%h want 0 0 3 deadbeef", sram_csb_n, sram_we_n, sram_addr, sram_din); end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if ({sram_csb_n, sram_we_n} !== 2'b01 || sram_addr !== 4'd3) begin
            errors++; $display("FAIL rd_pins got csb%b we%b a%h want 0 1 3", sram_csb_n, sram_we_n, sram_addr); end
        checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early got %b want 0", h_rvalid); end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (h_rvalid !== 1'b1 || d_rvalid !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_data got hv%b dv%b %h want 1 0 deadbeef", h_rvalid, d_rvalid, rdata); end
        checks++; if ({sram_csb_n, sram_we_n} !== 2'b11 || sram_addr !== 4'd3) begin
            errors++; $display("FAIL idle_pins got csb%b we%b a%h want 1 1 3", sram_csb_n, sram_we_n, sram_addr); end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL rd_pulse got %b want 0", h_rvalid); end
    endtask

    task automatic test_priority();
        bit eh;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drv(1, 0, 0, 4'd0, 0, 1, 0, 0, 4'd1, 0);
            eh = RR ? (k % 2 == 0) : 1'b1;
            checks++; if (h_gnt !== eh || d_gnt !== !eh) begin
                errors++; $display("FAIL prio_%0d got %b%b want %b%b", k, h_gnt, d_gnt, eh, !eh); end
        end
        idle(3);
    endtask

    task automatic test_lock_release();
        do_reset();
        drv(0, 0, 0, 0, 0, 1, 0, 1, 4'd5, 0);
        checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL lk_enter got %b want 1", d_gnt); end
        drv(1, 0, 0, 0, 0, 1, 0, 1, 4'd5, 0);
        checks++; if (h_gnt !== 1'b0 || d_gnt !== 1'b1) begin errors++; $display("FAIL lk_hold1 got %b%b want 01", h_gnt, d_gnt); end
        drv(1, 0, 0, 0, 0, 1, 1, 0, 4'd5, 32'h55);
        checks++; if (h_gnt !== 1'b0 || d_gnt !== 1'b1) begin errors++; $display("FAIL lk_hold2 got %b%b want 01", h_gnt, d_gnt); end
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (h_gnt !== 1'b1) begin errors++; $display("FAIL lk_after got %b want 1", h_gnt); end
        idle(2);
        drv(0, 0, 0, 0, 0, 1, 0, 1, 4'd6, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 1, 0, 0, 4'd6, 0);
        checks++; if (h_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL lk_idle_rel got %b%b want 10", h_gnt, d_gnt); end
        idle(3);
    endtask

    task automatic test_forced_release();
        bit hr;
        do_reset();
        // DPU holds lock 10 cycles; HOST requests from cycle 1 until served.
        hr = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drv(hr, 0, 0, 4'd1, 0, 1, 0, 1, 4'd2, 0);
            if (k == 4) begin
                checks++; if (h_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL frc_d_k%0d got %b%b want 10", k, h_gnt, d_gnt); end
            end else begin
                checks++; if (h_gnt !== 1'b0 || d_gnt !== 1'b1) begin errors++; $display("FAIL frc_d_k%0d got %b%b want 01", k, h_gnt, d_gnt); end
            end
            if (k == 0) hr = 1'b1;
            if (h_gnt) hr = 1'b0;
        end
        idle(3);
        // HOST holds lock; forced release must hand DPU one grant despite HOST priority.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drv(1, 0, (k < 4), 4'd1, 0, 1, 0, 0, 4'd2, 0);
            if (k == 4) begin
                checks++; if (h_gnt !== 1'b0 || d_gnt !== 1'b1) begin errors++; $display("FAIL frc_h_k%0d got %b%b want 01", k, h_gnt, d_gnt); end
            end else begin
                checks++; if (h_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL frc_h_k%0d got %b%b want 10", k, h_gnt, d_gnt); end
            end
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd [3] = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003};
        bit          ehv [5] = '{0, 0, 1, 0, 1};
        bit          edv [5] = '{0, 0, 0, 1, 0};
        logic [31:0] ed  [5];
        ed[0] = 0; ed[1] = 0; ed[2] = wd[0]; ed[3] = wd[1]; ed[4] = wd[2];
        do_reset();
        for (int i = 0; i < 3; i++) drv(1, 1, 0, 4'(i + 1), wd[i], 0, 0, 0, 0, 0);
        idle(2);
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: drv(1, 0, 0, 4'd1, 0, 0, 0, 0, 0, 0);
                1: drv(0, 0, 0, 0, 0, 1, 0, 0, 4'd2, 0);
                2: drv(1, 0, 0, 4'd3, 0, 0, 0, 0, 0, 0);
                default: drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            checks++; if (h_rvalid !== ehv[c] || d_rvalid !== edv[c]) begin
                errors++; $display("FAIL b2b_rv_c%0d got %b%b want %b%b", c, h_rvalid, d_rvalid, ehv[c], edv[c]); end
            if (ehv[c] || edv[c]) begin
                checks++; if (rdata !== ed[c]) begin errors++; $display("FAIL b2b_data_c%0d got %h want %h", c, rdata, ed[c]); end
            end
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        do_reset();
        drv(0, 0, 0, 0, 0, 1, 0, 1, 4'd2, 0);
        checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt got %b want 1", d_gnt); end
        @(negedge clk);
        reset = 1'b1; d_req = 1'b0; d_lock = 1'b0;
        #1;
        checks++; if (h_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL rm_gnt_rst got %b%b want 00", h_gnt, d_gnt); end
        @(negedge clk);
        reset = 1'b0;
        h_req = 1; h_we = 0; h_lock = 0; h_addr = 4'd1; d_req = 1; d_we = 0; d_lock = 0; d_addr = 4'd2;
        #1;
        checks++; if (d_rvalid !== 1'b0 || h_rvalid !== 1'b0) begin errors++; $display("FAIL rm_rvalid got %b%b want 00", h_rvalid, d_rvalid); end
        checks++; if ({sram_csb_n, sram_we_n} !== 2'b11) begin errors++; $display("FAIL rm_pins got %b%b want 11", sram_csb_n, sram_we_n); end
        checks++; if (h_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL rm_owner got %b%b want 10", h_gnt, d_gnt); end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (d_rvalid !== 1'b0 || h_rvalid !== 1'b0) begin errors++; $display("FAIL rm_rvalid2 got %b%b want 00", h_rvalid, d_rvalid); end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (h_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin errors++; $display("FAIL rm_newrd got %b%b want 10", h_rvalid, d_rvalid); end
        idle(2);
    endtask

    // Random traffic against an abstract model: owner/count/fairness as plain
    // integers, a reference memory and a return schedule keyed by cycle.
    task automatic test_random();
        int          own, cnt, fair, last, win, slot;
        int          exp_v [8];
        logic [31:0] exp_d [8];
        logic [31:0] ref_mem [16];
        bit          hr, hw, hl, dr, dw, dl, eh, ed, lk, we;
        logic [3:0]  ha, da, a;
        logic [31:0] hd, dd;
        do_reset();
        own = 0; cnt = 0; fair = 0; last = 2;
        for (int i = 0; i < 8; i++) exp_v[i] = 0;
        for (int c = 0; c < 400; c++) begin
            if (c < 16) begin
                hr = 1; hw = 1; hl = 0; ha = 4'(c); hd = $urandom; dr = 0; dw = 0; dl = 0; da = 0; dd = 0;
            end else begin
                hr = ($urandom % 4) != 0; hw = $urandom % 2; hl = ($urandom % 3) == 0; ha = 4'($urandom % 16); hd = $urandom;
                dr = ($urandom % 4) != 0; dw = $urandom % 2; dl = ($urandom % 3) == 0; da = 4'($urandom % 16); dd = $urandom;
            end
            drv(hr, hw, hl, ha, hd, dr, dw, dl, da, dd);
            eh = 0; ed = 0;
            if (own == 1) eh = hr;
            else if (own == 2) ed = dr;
            else if (hr && dr) begin
                if (fair != 0) win = fair;
                else win = RR ? ((last == 1) ? 2 : 1) : 1;
                eh = (win == 1); ed = (win == 2);
            end else begin
                eh = hr; ed = dr;
            end
            checks++; if (h_gnt !== eh || d_gnt !== ed) begin
                errors++; $display("FAIL rnd_gnt_c%0d got %b%b want %b%b", c, h_gnt, d_gnt, eh, ed); end
            slot = c % 8;
            checks++; if (h_rvalid !== (exp_v[slot] == 1) || d_rvalid !== (exp_v[slot] == 2)) begin
                errors++; $display("FAIL rnd_rv_c%0d got %b%b want id %0d", c, h_rvalid, d_rvalid, exp_v[slot]); end
            if (exp_v[slot] != 0) begin
                checks++; if (rdata !== exp_d[slot]) begin errors++; $display("FAIL rnd_data_c%0d got %h want %h", c, rdata, exp_d[slot]); end
            end
            exp_v[slot] = 0;
            win = eh ? 1 : (ed ? 2 : 0);
            if (win != 0) begin
                lk = (win == 1) ? hl : dl;
                we = (win == 1) ? hw : dw;
                a  = (win == 1) ? ha : da;
                if (we) ref_mem[a] = (win == 1) ? hd : dd;
                else begin
                    exp_v[(c + 1 + RL) % 8] = win;
                    exp_d[(c + 1 + RL) % 8] = ref_mem[a];
                end
                fair = 0; last = win;
                if (lk) begin
                    cnt++; own = win;
                    if (cnt == LMAX) begin own = 0; cnt = 0; fair = 3 - win; end
                end else begin
                    own = 0; cnt = 0;
                end
            end else if (own != 0 && !((own == 1) ? hr : dr)) begin
                own = 0; cnt = 0;
            end
        end
        idle(4);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_priority();
        test_lock_release();
        test_forced_release();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
